// File: rtl/spi_xfer_ctrl_if.sv
// Bundle between the SPI transfer controller, its two requesters and the
// sender/receiver shift registers.
interface spi_xfer_ctrl_if;
    logic       req0;
    logic [7:0] data0;
    logic       req1;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata;
    logic       err;
    logic       busy;
    logic       s_write;
    logic [7:0] s_data;
    logic       te;
    logic       re;
    logic       r_read;
    logic [7:0] r_data;
    logic       r_full;

    // Requesters drive req/data as levels; the controller answers with a
    // level grant for the whole transfer and a one-cycle done pulse, with no
    // back-pressure on done.
    modport slave (
        input  req0, data0, req1, data1, r_data, r_full,
        output gnt0, gnt1, done0, done1, rdata, err, busy,
        output s_write, s_data, te, re, r_read
    );

    modport master (
        output req0, data0, req1, data1, r_data, r_full,
        input  gnt0, gnt1, done0, done1, rdata, err, busy,
        input  s_write, s_data, te, re, r_read
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Two-requester round-robin SPI transfer controller: load sender, shift BITS
// cycles, capture receiver byte, report completion to the granted requester.
module spi_xfer_ctrl #(
    parameter int BITS = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    spi_xfer_ctrl_if.slave   bus,
    output logic [2:0]       o_state
);
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_win;
    logic [7:0]    r_data;
    logic          r_err;
    logic [7:0]    r_rdata;
    logic          w_any_req;
    logic          w_win;

    assign w_any_req = bus.req0 | bus.req1;
    // Contention goes to whoever was not served last; otherwise the lone requester.
    assign w_win     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign o_state   = r_state;
    assign bus.rdata = r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_win   <= 1'b0;
            r_data  <= 8'h00;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_win  <= w_win;
                        r_last <= w_win;
                        r_data <= w_win ? bus.data1 : bus.data0;
                    end
                end
                S_LOAD:  r_cnt <= CW'(BITS - 1);
                S_SHIFT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_CAPTURE: begin
                    // Byte lands here so RDATA is already valid during the done pulse.
                    r_err   <= ~bus.r_full;
                    r_rdata <= bus.r_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        bus.busy    = 1'b0;
        bus.gnt0    = 1'b0;
        bus.gnt1    = 1'b0;
        bus.done0   = 1'b0;
        bus.done1   = 1'b0;
        bus.err     = 1'b0;
        bus.s_write = 1'b0;
        bus.s_data  = 8'h00;
        bus.te      = 1'b0;
        bus.re      = 1'b0;
        bus.r_read  = 1'b0;
        if (r_state != S_IDLE) begin
            bus.busy = 1'b1;
            bus.gnt0 = ~r_win;
            bus.gnt1 = r_win;
        end
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_next = S_LOAD;
            end
            S_LOAD: begin
                bus.s_write = 1'b1;
                bus.s_data  = r_data;
                w_next      = S_SHIFT;
            end
            S_SHIFT: begin
                bus.te = 1'b1;
                bus.re = 1'b1;
                if (r_cnt == '0) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                bus.r_read = 1'b1;
                w_next     = S_FINISH;
            end
            S_FINISH: begin
                bus.done0 = ~r_win;
                bus.done1 = r_win;
                bus.err   = r_err;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: loopback shift-register peripheral, timeline
// reference model, and a scoreboard of expected completions.
module tb_spi_xfer_ctrl;
    localparam int BITS = 8;
    localparam int W    = 26;  // {done_cycle[15:0], id, err, data[7:0]}

    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if bus();

    spi_xfer_ctrl #(.BITS(BITS)) dut (
        .i_clk   (clk),
        .i_clr   (clr),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Loopback peripheral: sender MSB feeds receiver LSB on each shift.
    logic [7:0] tx_sr = 8'h00;
    logic [7:0] rx_sr = 8'h00;
    int         rx_cnt = 0;
    logic       force_empty;

    always @(posedge clk) begin
        if (bus.s_write) begin
            tx_sr  <= bus.s_data;
            rx_cnt <= 0;
        end else if (bus.te) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
        if (bus.re) begin
            rx_sr  <= {rx_sr[6:0], tx_sr[7]};
            rx_cnt <= rx_cnt + 1;
        end
        if (bus.r_read) rx_cnt <= 0;
    end
    assign bus.r_data = rx_sr;
    assign bus.r_full = (rx_cnt >= BITS) && !force_empty;

    // Reference model: a transfer is a fixed-length window starting the cycle
    // after an IDLE evaluation; IDLE evaluations happen every cycle when idle.
    int         cur = 0;
    int         next_idle = 0;
    int         t_load = -1000;
    logic       last = 1'b1;
    logic       act_win = 1'b0;
    logic [7:0] act_data = 8'h00;
    logic       act_err = 1'b0;
    logic [7:0] last_rdata = 8'h00;
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin : ref_model
        if (clr) begin
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (int'(exp_q[i][25:10]) > cur) exp_q.delete(i);
            t_load     = -1000;
            next_idle  = cur + 1;
            last       = 1'b1;
            last_rdata = 8'h00;
        end else begin
            if (cur == t_load + BITS + 1) begin
                act_err    = force_empty;
                last_rdata = act_data;
                if (exp_q.size() > 0) exp_q[exp_q.size() - 1][8] = force_empty;
            end
            if (cur == next_idle) begin
                if (bus.req0 || bus.req1) begin
                    act_win   = (bus.req0 && bus.req1) ? !last : bus.req1;
                    act_data  = act_win ? bus.data1 : bus.data0;
                    last      = act_win;
                    t_load    = cur + 1;
                    next_idle = cur + BITS + 4;
                    exp_q.push_back({16'(cur + BITS + 3), act_win, 1'b0, act_data});
                end else begin
                    next_idle = cur + 1;
                end
            end
        end
        cur = cur + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cur, act, exp);
        end
    endtask

    // Monitor: per-cycle output check plus scoreboard pop on every done pulse.
    always @(negedge clk) begin : monitor
        int         off;
        logic       in_x;
        logic [25:0] exp_v;
        logic [25:0] act_v;
        logic [W-1:0] e;
        if (cur >= 1) begin
            off  = cur - t_load;
            in_x = (off >= 0) && (off <= BITS + 2);
            exp_v = '0;
            exp_v[7:0] = last_rdata;
            if (in_x) begin
                exp_v[25] = 1'b1;
                exp_v[24] = !act_win;
                exp_v[23] = act_win;
                if (off == 0) begin
                    exp_v[22]    = 1'b1;
                    exp_v[21:14] = act_data;
                end
                if (off >= 1 && off <= BITS) begin
                    exp_v[13] = 1'b1;
                    exp_v[12] = 1'b1;
                end
                if (off == BITS + 1) exp_v[11] = 1'b1;
                if (off == BITS + 2) begin
                    exp_v[10] = !act_win;
                    exp_v[9]  = act_win;
                    exp_v[8]  = act_err;
                end
            end
            act_v = {bus.busy, bus.gnt0, bus.gnt1, bus.s_write, bus.s_data,
                     bus.te, bus.re, bus.r_read, bus.done0, bus.done1, bus.err, bus.rdata};
            chk("outputs", 64'(act_v), 64'(exp_v));
            if (bus.done0 || bus.done1) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("completion", 64'({16'(cur), bus.done1, bus.err, bus.rdata}), 64'(e));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_wait();
        int k;
        k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("idle_timeout", 64'(1), 64'(0));
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        force_empty = 1'b0;
        tick(2);
        clr = 1'b0;
        bus.req0 = 1'b0;
        tick(2);

        // Both held after reset: order 0,1,0,1
        bus.data0 = 8'h5F;
        bus.data1 = 8'hA0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick(40);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        idle_wait();
        tick(2);

        // Single transfer
        bus.data0 = 8'h43;
        bus.req0 = 1'b1;
        tick(1);
        bus.req0 = 1'b0;
        bus.data0 = 8'hFF;
        idle_wait();
        tick(2);

        // Clear on the 4th shift cycle, then a normal transfer
        bus.data0 = 8'h3C;
        bus.req0 = 1'b1;
        tick(1);
        bus.req0 = 1'b0;
        tick(4);
        do_reset();
        bus.data0 = 8'h96;
        bus.req0 = 1'b1;
        tick(1);
        bus.req0 = 1'b0;
        idle_wait();
        tick(2);

        // Receiver never full -> error with done1
        force_empty = 1'b1;
        bus.data1 = 8'hC5;
        bus.req1 = 1'b1;
        tick(1);
        bus.req1 = 1'b0;
        idle_wait();
        force_empty = 1'b0;
        tick(2);

        // Request dropped mid-transfer still completes
        bus.data1 = 8'h2B;
        bus.req1 = 1'b1;
        tick(3);
        bus.req1 = 1'b0;
        bus.data1 = 8'h00;
        idle_wait();
        tick(2);

        // Randomized traffic with occasional clears and empty receiver
        for (int i = 0; i < 600; i++) begin
            bus.req0 = ($urandom_range(0, 2) == 0);
            bus.req1 = ($urandom_range(0, 2) == 0);
            bus.data0 = 8'($urandom_range(0, 255));
            bus.data1 = 8'($urandom_range(0, 255));
            clr = ($urandom_range(0, 59) == 0);
            force_empty = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        clr = 1'b0;
        force_empty = 1'b0;
        tick(1);
        idle_wait();
        tick(3);
        chk("pending_completions", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
